hilbert_seq: RTL and testbench

Sequencer and multiply-accumulate engine for the 9-register Hilbert rotating chain (order 8).
- Accepts one input sample through a valid/ready handshake and pulses the chain's load enable.
- Drives the chain's stop flag so the chain rotates exactly one full revolution.
- Multiplies each tap presented on the chain output by its 1Q10 coefficient and accumulates.
- Emits the rounded, saturated 16-bit imaginary (quadrature) sample, one result per accepted input.

---
 rtl/hilbert_seq.sv | 128 ++++++++++++
 tb/tb_hilbert_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_seq.sv
// Sequencer and MAC engine for the 9-tap Hilbert rotating chain.
// One sample is accepted, then the chain is rotated once around. Each tap
// that appears on chain_out is weighted by its coefficient and accumulated.
// The result is rounded, saturated and presented once on im.
module hilbert_seq #(
    parameter int                 ORDER_HF = 8,
    parameter logic signed [10:0] HA       = 11'sd245,
    parameter logic signed [10:0] HB       = 11'sd641
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [15:0] in_sample,
    output logic               in_ready,
    output logic signed [15:0] chain_in,
    output logic               chain_en,
    output logic               cnt_stop,
    input  logic signed [15:0] chain_out,
    output logic signed [15:0] im,
    output logic               out_valid,
    output logic               ovf
);

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    // Coefficients are widened to 12 bits so that negating them cannot overflow.
    localparam logic signed [11:0] CA = 12'(HA);
    localparam logic signed [11:0] CB = 12'(HB);
    localparam logic [3:0]         NTAPS = 4'(ORDER_HF + 1);

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic signed [31:0] acc_q;
    logic signed [15:0] im_q;
    logic               out_valid_q;
    logic               ovf_q;

    logic [3:0]         tap;
    logic signed [11:0] coef;
    logic signed [27:0] prod;
    logic signed [31:0] acc_d;
    logic signed [31:0] rnd;
    logic signed [15:0] sat_d;
    logic               ovf_d;

    // While the chain rotates, chain_out holds tap cnt-1.
    assign tap = cnt_q - 4'd1;

    // Antisymmetric coefficient set: only taps 0, 2, 6 and 8 are non-zero.
    always_comb begin
        coef = 12'sd0;
        case (tap)
            4'd0:    coef = -CA;
            4'd2:    coef = -CB;
            4'd6:    coef = CB;
            4'd8:    coef = CA;
            default: coef = 12'sd0;
        endcase
    end

    // The 16x12 product fits in 28 bits. Nine such terms cannot overflow 32 bits.
    assign prod  = $signed({{12{chain_out[15]}}, chain_out}) * $signed({{16{coef[11]}}, coef});
    assign acc_d = acc_q + $signed({{4{prod[27]}}, prod});
    assign rnd   = (acc_d + 32'sd512) >>> 10;

    // Clip the rounded value to the 16-bit output range and flag any clipping.
    always_comb begin
        sat_d = rnd[15:0];
        ovf_d = 1'b0;
        if (rnd > 32'sd32767) begin
            sat_d = 16'sh7fff;
            ovf_d = 1'b1;
        end else if (rnd < -32'sd32768) begin
            sat_d = -16'sd32768;
            ovf_d = 1'b1;
        end
    end

    // Sequencer FSM: accept in IDLE, run one MAC per rotation in ROT, publish in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= 32'sd0;
            im_q        <= 16'sd0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                    if (in_valid) begin
                        cnt_q   <= NTAPS;
                        acc_q   <= 32'sd0;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        im_q        <= sat_d;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is gated by reset so that it stays low while reset is held.
    assign in_ready  = reset & (state_q == IDLE);
    assign chain_en  = in_valid & in_ready;
    assign chain_in  = in_sample;
    assign cnt_stop  = (cnt_q == 4'd0);
    assign im        = im_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hilbert_seq.sv
// Bench for hilbert_seq: external rotating chain model, cycle-level reference
// (history of accepted samples -> FIR sum -> round -> saturate), directed and
// random stimulus.
module tb_hilbert_seq;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic               in_ready;
    logic signed [15:0] chain_in;
    logic               chain_en;
    logic               cnt_stop;
    logic signed [15:0] chain_out;
    logic signed [15:0] im;
    logic               out_valid;
    logic               ovf;

    hilbert_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .chain_in  (chain_in),
        .chain_en  (chain_en),
        .cnt_stop  (cnt_stop),
        .chain_out (chain_out),
        .im        (im),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    // Environment: the 9-register chain. It loads on chain_en and rotates while the stop flag is low.
    logic signed [15:0] chain [0:8];
    assign chain_out = chain[8];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) chain[i] <= 16'sd0;
        end else if (chain_en) begin
            chain[0] <= chain_in;
            for (int i = 1; i < 9; i++) chain[i] <= chain[i-1];
        end else if (!cnt_stop) begin
            chain[0] <= chain[8];
            for (int i = 1; i < 9; i++) chain[i] <= chain[i-1];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input integer act, input integer exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: filter the history of accepted samples directly.
    int coefs [0:8] = '{-245, 0, -641, 0, 0, 0, 641, 0, 245};
    int hist  [0:8];

    typedef struct {
        longint due;
        int     im;
        int     ovf;
    } exp_t;
    exp_t   q[$];
    longint cyc = 0;
    longint ready_cyc = 0;
    longint rot_lo = 1;
    longint rot_hi = 0;
    int     last_im = 0;

    function automatic void model_eval(output int r, output int o);
        longint s;
        longint t;
        s = 0;
        for (int k = 0; k < 9; k++) s += longint'(coefs[k]) * hist[k];
        t = s + 512;
        t = (t >= 0) ? t / 1024 : -((-t + 1023) / 1024);
        o = 0;
        if (t > 32767) begin t = 32767; o = 1; end
        if (t < -32768) begin t = -32768; o = 1; end
        r = int'(t);
    endfunction

    // Per-cycle compare against the reference timing and arithmetic.
    always @(negedge clock) begin
        bit   exp_rdy, exp_en, exp_ov;
        exp_t e;
        cyc++;
        if (!reset) begin
            q.delete();
            for (int k = 0; k < 9; k++) hist[k] = 0;
            ready_cyc = 0; rot_lo = 1; rot_hi = 0; last_im = 0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_im", im, 0);
            chk("rst_cnt_stop", cnt_stop, 1);
            chk("rst_chain_en", chain_en, 0);
        end else begin
            exp_rdy = (cyc >= ready_cyc);
            exp_en  = exp_rdy && (in_valid === 1'b1);
            chk("in_ready", in_ready, exp_rdy);
            chk("chain_en", chain_en, exp_en);
            if (exp_en) chk("chain_in", chain_in, in_sample);
            chk("cnt_stop", cnt_stop, !(cyc >= rot_lo && cyc <= rot_hi));
            exp_ov = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                e = q.pop_front();
                chk("im", im, e.im);
                chk("ovf", ovf, e.ovf);
                last_im = e.im;
            end else begin
                chk("im_hold", im, last_im);
                chk("ovf_idle", ovf, 0);
            end
            if (exp_en) begin
                for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(in_sample);
                model_eval(e.im, e.ovf);
                e.due = cyc + 10;
                q.push_back(e);
                ready_cyc = cyc + 11;
                rot_lo = cyc + 1;
                rot_hi = cyc + 9;
            end
        end
    end

    // Offer one sample, wait for acceptance and for its result (both bounded).
    task automatic send(input logic signed [15:0] s, output int rim, output int rovf);
        bit acc;
        bit got;
        acc = 0; got = 0; rim = 0; rovf = 0;
        @(posedge clock); #1;
        in_valid = 1'b1; in_sample = s;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (in_ready) begin acc = 1; break; end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("accept_timeout", acc, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (out_valid) begin rim = im; rovf = ovf; got = 1; break; end
        end
        chk("result_timeout", got, 1);
    endtask

    int imp_in  [0:8] = '{1000, 0, 0, 0, 0, 0, 0, 0, 0};
    int imp_exp [0:8] = '{-239, 0, -626, 0, 0, 0, 626, 0, 239};
    int sat_in  [0:8] = '{32767, 0, 32767, 0, 0, 0, -32768, 0, -32768};

    initial begin
        int r, o, hold, ne, ns;
        bit acc;
        reset = 1'b0; in_valid = 1'b0; in_sample = 16'sd0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;

        // Impulse response.
        for (int i = 0; i < 9; i++) begin
            send(16'(imp_in[i]), r, o);
            chk($sformatf("impulse_im[%0d]", i), r, imp_exp[i]);
            chk($sformatf("impulse_ovf[%0d]", i), o, 0);
        end

        // Saturation.
        for (int i = 0; i < 9; i++) begin
            send(16'(sat_in[i]), r, o);
            if (i == 7) begin
                chk("sat8_im", r, 0);
                chk("sat8_ovf", o, 0);
            end
            if (i == 8) begin
                chk("sat9_im", r, 32767);
                chk("sat9_ovf", o, 1);
            end
        end

        // DC input cancels.
        for (int i = 0; i < 9; i++) send(16'sd1000, r, o);
        chk("dc_im", r, 0);
        chk("dc_ovf", o, 0);

        // Idle hold.
        hold = int'(im);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            chk("idle_im", im, hold);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_cnt_stop", cnt_stop, 1);
            chk("idle_chain_en", chain_en, 0);
        end

        // Continuous in_valid: one accept every 11 cycles, 9 rotation cycles each.
        @(posedge clock); #1;
        in_valid = 1'b1; in_sample = 16'($urandom);
        ne = 0; ns = 0;
        for (int i = 0; i < 55; i++) begin
            @(negedge clock);
            if (chain_en) ne++;
            if (!cnt_stop) ns++;
            @(posedge clock); #1;
            in_sample = 16'($urandom);
        end
        in_valid = 1'b0;
        chk("cont_accepts", ne, 5);
        chk("cont_rot_cycles", ns, 45);
        repeat (15) @(posedge clock);

        // Reset during ROT abandons the sample.
        @(posedge clock); #1;
        in_valid = 1'b1; in_sample = 16'sd12345;
        acc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (in_ready) begin acc = 1; break; end
        end
        chk("midrst_accept", acc, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_cnt_stop", cnt_stop, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            chk("midrst_no_out", out_valid, 0);
        end
        send(16'sd2000, r, o);
        chk("post_rst_im", r, -479);

        // Random traffic; in_valid also toggles while busy, which must be ignored.
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1;
            in_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       in_sample = 16'sh7fff;
                1:       in_sample = 16'sh8000;
                default: in_sample = 16'($urandom);
            endcase
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clock);
        chk("drain_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
